// File: rtl/sweep_marker_detect_if.sv
// sweep_marker_detect_if: marker configuration, sweep position stream and marker outputs
interface sweep_marker_detect_if #(
    parameter int MW  = 12,
    parameter int PWW = 8
);
    logic [MW-1:0]  Marker_Value;
    logic           Marker_EN;
    logic [PWW-1:0] Pulse_Width;
    logic           Sweep_Start;
    logic           Sweep_Dir;
    logic [MW-1:0]  Sweep_Pos;
    logic           Sweep_Valid;
    logic           Marker_Out;
    logic           Marker_Hit;
    logic           Marker_Busy;

    modport master (
        output Marker_Value, Marker_EN, Pulse_Width, Sweep_Start, Sweep_Dir, Sweep_Pos, Sweep_Valid,
        input  Marker_Out, Marker_Hit, Marker_Busy
    );

    modport slave (
        input  Marker_Value, Marker_EN, Pulse_Width, Sweep_Start, Sweep_Dir, Sweep_Pos, Sweep_Valid,
        output Marker_Out, Marker_Hit, Marker_Busy
    );
endinterface

// File: rtl/sweep_marker_detect.sv
// sweep_marker_detect: detects the sweep step reaching/crossing the latched marker and emits one pulse per sweep
module sweep_marker_detect #(
    parameter int MW  = 12,
    parameter int PWW = 8
) (
    input logic                  Clock,
    input logic                  Reset,
    sweep_marker_detect_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FIRST, TRACK, PULSE, DONE} state_t;

    state_t         state, state_d;
    logic [MW-1:0]  m, p, p_d;
    logic           dir;
    logic [PWW-1:0] w, cnt, cnt_d;
    logic           hit, out_d, hit_d, busy_d;
    logic           marker_out, marker_hit, marker_busy;

    // A new sweep start masks any sample arriving in the same cycle
    assign hit = bus.Sweep_Valid && !bus.Sweep_Start &&
                 (state == FIRST ? bus.Sweep_Pos == m :
                  state == TRACK && (dir ? (p > m && bus.Sweep_Pos <= m) : (p < m && bus.Sweep_Pos >= m)));

    assign bus.Marker_Out  = marker_out;
    assign bus.Marker_Hit  = marker_hit;
    assign bus.Marker_Busy = marker_busy;

    // State, sweep context and registered outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= IDLE;
            m           <= '0;
            dir         <= 1'b0;
            w           <= '0;
            p           <= '0;
            cnt         <= '0;
            marker_out  <= 1'b0;
            marker_hit  <= 1'b0;
            marker_busy <= 1'b0;
        end else begin
            state       <= state_d;
            p           <= p_d;
            cnt         <= cnt_d;
            marker_out  <= out_d;
            marker_hit  <= hit_d;
            marker_busy <= busy_d;
            if (bus.Sweep_Start) begin
                m   <= bus.Marker_Value;
                dir <= bus.Sweep_Dir;
                w   <= bus.Pulse_Width == '0 ? PWW'(1) : bus.Pulse_Width;
            end
        end
    end

    // Next state, previous position and pulse countdown
    always_comb begin
        state_d = state;
        p_d     = p;
        cnt_d   = cnt;
        if (bus.Sweep_Start)
            state_d = bus.Marker_EN ? FIRST : IDLE;
        else if (hit) begin
            state_d = PULSE;
            cnt_d   = w;
        end else
            case (state)
                FIRST, TRACK:
                    if (bus.Sweep_Valid) begin
                        state_d = TRACK;
                        p_d     = bus.Sweep_Pos;
                    end
                PULSE: begin
                    cnt_d   = cnt - 1'b1;
                    state_d = cnt <= PWW'(1) ? DONE : PULSE;
                end
                default: ;
            endcase
    end

    // Outputs follow the next state so they appear one edge after the cause
    always_comb begin
        out_d  = state_d == PULSE;
        hit_d  = hit;
        busy_d = state_d == FIRST || state_d == TRACK || state_d == PULSE;
    end
endmodule

// File: tb/tb_sweep_marker_detect.sv
// tb_sweep_marker_detect: directed test-plan steps plus random sweeps checked against a behavioural model
module tb_sweep_marker_detect;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    sweep_marker_detect_if #(.MW(12), .PWW(8)) bus ();
    sweep_marker_detect #(.MW(12), .PWW(8)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: a sweep is "searching" until its single hit, then a pulse of w cycles remains
    int m_m, m_dir, m_w, m_prev, m_left;
    bit m_search, m_have, m_hitq;
    int obs_hits, obs_high;

    task automatic model();
        int pos;
        pos    = int'(bus.Sweep_Pos);
        m_hitq = 1'b0;
        if (!Reset) begin
            m_search = 0; m_left = 0; m_have = 0; m_prev = 0; m_m = 0; m_dir = 0; m_w = 0;
        end else if (bus.Sweep_Start) begin
            m_m      = int'(bus.Marker_Value);
            m_dir    = int'(bus.Sweep_Dir);
            m_w      = bus.Pulse_Width == 0 ? 1 : int'(bus.Pulse_Width);
            m_search = bus.Marker_EN;
            m_have   = 0;
            m_left   = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_search && bus.Sweep_Valid) begin
            if (!m_have) begin
                if (pos == m_m) m_hitq = 1;
                else begin m_prev = pos; m_have = 1; end
            end else if (m_dir == 0 ? (m_prev < m_m && pos >= m_m) : (m_prev > m_m && pos <= m_m))
                m_hitq = 1;
            else
                m_prev = pos;
            if (m_hitq) begin m_search = 0; m_left = m_w; end
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model();
        #1;
        obs_hits += int'(bus.Marker_Hit);
        obs_high += int'(bus.Marker_Out);
        check("Marker_Out", bus.Marker_Out, m_left > 0);
        check("Marker_Hit", bus.Marker_Hit, m_hitq);
        check("Marker_Busy", bus.Marker_Busy, m_search || m_left > 0);
    endtask

    task automatic start(input logic [11:0] mv, input logic en, input logic d, input logic [7:0] pw);
        bus.Marker_Value = mv; bus.Marker_EN = en; bus.Sweep_Dir = d; bus.Pulse_Width = pw;
        bus.Sweep_Start = 1'b1;
        tick();
        bus.Sweep_Start = 1'b0;
        obs_hits = 0; obs_high = 0;
    endtask

    task automatic pos(input logic [11:0] v);
        bus.Sweep_Valid = 1'b1; bus.Sweep_Pos = v;
        tick();
        bus.Sweep_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [11:0] walk;
    bit          wdir;

    initial begin
        bus.Marker_Value = '0; bus.Marker_EN = 1'b0; bus.Pulse_Width = '0; bus.Sweep_Start = 1'b0;
        bus.Sweep_Dir = 1'b0; bus.Sweep_Pos = '0; bus.Sweep_Valid = 1'b0;
        // power-up reset
        idle(2);
        Reset = 1'b1;
        idle(1);

        // ascending exact hit, W = 4
        start(12'h100, 1, 0, 8'd4);
        pos(12'h0FE); pos(12'h0FF); pos(12'h100);
        idle(6);
        check_n("exact_hits", obs_hits, 1);
        check_n("exact_width", obs_high, 4);

        // ascending step-over, then descending
        start(12'h105, 1, 0, 8'd2);
        pos(12'h0F0); pos(12'h100); pos(12'h110);
        idle(4);
        check_n("stepover_hits", obs_hits, 1);
        start(12'h105, 1, 1, 8'd2);
        pos(12'h120); pos(12'h110); pos(12'h100);
        idle(4);
        check_n("desc_hits", obs_hits, 1);

        // disabled sweep
        start(12'h200, 0, 0, 8'd3);
        for (int i = 0; i < 8; i++) pos(12'h1F0 + 12'(i * 4));
        check_n("disabled_hits", obs_hits, 0);

        // mid-sweep config changes are ignored
        start(12'h200, 1, 0, 8'd3);
        pos(12'h040);
        bus.Marker_Value = 12'h050; bus.Pulse_Width = 8'd9; bus.Sweep_Dir = 1'b1; bus.Marker_EN = 1'b0;
        pos(12'h050); pos(12'h060); pos(12'h100); pos(12'h1FF);
        check_n("latch_nohit", obs_hits, 0);
        pos(12'h200);
        idle(5);
        check_n("latch_hits", obs_hits, 1);
        check_n("latch_width", obs_high, 3);

        // abort a long pulse with a new sweep, then re-hit
        start(12'h100, 1, 0, 8'd10);
        pos(12'h0F0); pos(12'h100);
        idle(3);
        start(12'h100, 1, 0, 8'd3);
        check("abort_low", bus.Marker_Out, 1'b0);
        pos(12'h0F0); pos(12'h100);
        idle(5);
        check_n("rehit_hits", obs_hits, 1);

        // wrap is not a crossing, once per sweep
        start(12'h010, 1, 0, 8'd2);
        pos(12'hFF0); pos(12'h000);
        check_n("wrap_nohit", obs_hits, 0);
        pos(12'h020); pos(12'h030); pos(12'h000); pos(12'h040);
        idle(3);
        check_n("once_hits", obs_hits, 1);

        // reset mid-pulse
        start(12'h100, 1, 0, 8'd20);
        pos(12'h0F0); pos(12'h100);
        idle(3);
        Reset = 1'b0;
        tick();
        check("rst_out", bus.Marker_Out, 1'b0);
        Reset = 1'b1;
        idle(2);

        // pulse width 0 gives a single cycle
        start(12'h080, 1, 0, 8'd0);
        pos(12'h070); pos(12'h090);
        idle(3);
        check_n("pw0_width", obs_high, 1);

        // random sweeps
        walk = 12'h000; wdir = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            Reset = $urandom_range(0, 299) != 0;
            bus.Sweep_Start = $urandom_range(0, 39) == 0;
            bus.Sweep_Dir   = 1'($urandom_range(0, 1));
            bus.Marker_EN   = $urandom_range(0, 3) != 0;
            bus.Pulse_Width = $urandom_range(0, 19) == 0 ? 8'hFF : 8'($urandom_range(0, 5));
            if (bus.Sweep_Start) wdir = bus.Sweep_Dir;
            bus.Marker_Value = wdir ? walk - 12'($urandom_range(0, 300)) : walk + 12'($urandom_range(0, 300));
            bus.Sweep_Valid = $urandom_range(0, 9) < 7;
            if (bus.Sweep_Valid) begin
                if ($urandom_range(0, 7) == 0) walk = 12'($urandom_range(0, 4095));
                else walk = wdir ? walk - 12'($urandom_range(0, 30)) : walk + 12'($urandom_range(0, 30));
            end
            bus.Sweep_Pos = walk;
            tick();
        end
        bus.Sweep_Start = 1'b0; bus.Sweep_Valid = 1'b0; Reset = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sweep_marker_detect.md
# sweep_marker_detect

Consumer side of the sweep marker value register. Latches the 12-bit marker value at the start of each sweep, tracks the sweep position stream from the sweep controller, and detects the step at which the sweep reaches or crosses the marker. It then drives a marker output pulse of programmable width and a one-cycle hit strobe, once per sweep. It sits between the marker value register and the front-panel/trigger output logic.

## Interface
- `MW`, 12: marker/position width.
- `PWW`, 8: pulse-width field width.

Ports:
- `Clock`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Marker_Value`  in  MW  marker value from the marker load register.
- `Marker_EN`  in  1  1 = marker function enabled; sampled at sweep start.
- `Pulse_Width`  in  PWW  marker pulse length in cycles; 0 is treated as 1.
- `Sweep_Start`  in  1  one-cycle strobe at the beginning of each sweep.
- `Sweep_Dir`  in  1  0 = ascending sweep, 1 = descending; sampled at `Sweep_Start`.
- `Sweep_Pos`  in  MW  current sweep position.
- `Sweep_Valid`  in  1  `Sweep_Pos` holds a new step this cycle.
- `Marker_Out`  out  1  marker pulse, registered.
- `Marker_Hit`  out  1  one-cycle strobe, coincident with the first cycle of `Marker_Out`.
- `Marker_Busy`  out  1  high in FIRST, TRACK and PULSE.

## Operation
- **Reset** (`Reset` = 0 at a clock edge) takes effect in the same cycle:
  - `Marker_Out`, `Marker_Hit` and `Marker_Busy` = 0.
  - State = IDLE.
  - Latched marker `M`, latched direction, previous position `P` and pulse counter = 0.
- **States:** IDLE, FIRST, TRACK, PULSE, DONE.
- **`Sweep_Start` = 1** from any state takes priority over every other event.
  - Latch `M` = `Marker_Value`, `dir` = `Sweep_Dir`, `W` = max(`Pulse_Width`, 1).
  - Go to FIRST if `Marker_EN` = 1, otherwise go to IDLE.
  - A pulse in progress is aborted: `Marker_Out` is 0 from the next cycle.
  - A `Sweep_Valid` in the same cycle is ignored.
- **FIRST**, on `Sweep_Valid`:
  - If `Sweep_Pos` == `M`, it is a hit.
  - Otherwise set `P` = `Sweep_Pos` and go to TRACK.
  - A first sample already past `M` is not a hit.
- **TRACK**, on `Sweep_Valid`, with `c` = `Sweep_Pos` (unsigned compare):
  - Ascending (`dir` = 0): hit when `P` < `M` and `c` >= `M`.
  - Descending (`dir` = 1): hit when `P` > `M` and `c` <= `M`.
  - If there is no hit, `P` = `c`.
  - Steps against the sweep direction simply update `P`.
  - A wrap-around from 0xFFF to 0x000 is not a crossing, because `P` > `c` in ascending mode.
- **On a hit:** go to PULSE, load the counter with `W`, set `Marker_Out` = 1 and `Marker_Hit` = 1 (one cycle only).
- **PULSE:**
  - The counter decrements every cycle.
  - When the counter reaches 1, go to DONE, with `Marker_Out` = 0 in the following cycle.
  - `Sweep_Valid` is ignored.
- **DONE:** hold until `Sweep_Start`. There is at most one hit per sweep.
- **IDLE:** `Sweep_Valid` is ignored.
- `Marker_Value`, `Marker_EN`, `Pulse_Width` and `Sweep_Dir` changes mid-sweep have no effect until the next `Sweep_Start`.

## Timing
- Hit latency: `Marker_Out` and `Marker_Hit` rise at the first clock edge after the qualifying `Sweep_Valid` cycle (1 cycle).
- `Marker_Out` stays high for exactly `W` cycles.
  - `Pulse_Width` = 0 gives a 1-cycle pulse.
  - 0xFF gives 255 cycles.
- `Sweep_Start` during PULSE: `Marker_Out` falls at the next edge and the new sweep is armed in the same cycle. A hit can occur on the first `Sweep_Valid` after that edge.
- `Marker_Busy` is registered and follows the state with 1-cycle latency from the triggering input.
- Back-to-back `Sweep_Valid` every cycle is supported; there is no throughput restriction.
- `Reset` low mid-pulse: all outputs are 0 at the next edge.

## Test plan
- **Ascending exact hit:** `Marker_Value` = 0x100, `W` = 4, `Sweep_Start`, then positions 0x0FE, 0x0FF, 0x100 with `Sweep_Valid` every cycle → `Marker_Out` high for 4 cycles starting 1 cycle after 0x100, with one `Marker_Hit` strobe.
- **Ascending step-over and direction check:** `M` = 0x105, steps of 0x010 from 0x0F0 → hit on 0x100→0x110. Then `Sweep_Dir` = 1 with `M` = 0x105 and positions 0x120, 0x110, 0x100 → hit on the 0x100 sample.
- **Disable and latching:** `Marker_EN` = 0 at `Sweep_Start` → no pulse for any positions, `Marker_Busy` = 0. Changing `Marker_Value` mid-sweep from 0x200 to 0x050 while positions pass 0x050 → no hit; the hit occurs at 0x200.
- **Abort:** `W` = 10, hit, then `Sweep_Start` 3 cycles later → `Marker_Out` is low in the next cycle, and a re-hit occurs on a later qualifying sample.
- **Once per sweep and wrap:** ascending `M` = 0x010, positions 0xFF0, 0x000, 0x020, 0x030 → a single hit on 0x020 only; no hit at the 0xFF0→0x000 wrap; no second hit afterwards.
- **Reset:** reset asserted mid-PULSE, and at power-up → all outputs are 0 one edge later. `Pulse_Width` = 0 → a 1-cycle pulse.
